// File: rtl/intr_ctrl.sv
// Vectored interrupt controller: eight rising-edge sources, IMASK/IPEND/ISTAT registers,
// fixed priority (bit 0 highest) and a non-nesting REQ/SERVICE handshake with the CPU.
module intr_ctrl #(
    parameter logic [15:0] IO_BASE   = 16'h0040,
    parameter logic [15:0] VECT_BASE = 16'h0002,
    parameter logic [15:0] VECT_STEP = 16'h0002
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  irq,
    input  logic [15:0] address,
    input  logic [7:0]  wb,
    input  logic        w,
    output logic [7:0]  dout,
    input  logic        sreg_i,
    output logic        intr_req,
    output logic [15:0] intr_vect,
    input  logic        intr_ack,
    input  logic        reti
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    localparam logic [15:0] ADDR_IMASK = IO_BASE;
    localparam logic [15:0] ADDR_IPEND = IO_BASE + 16'd1;
    localparam logic [15:0] ADDR_ISTAT = IO_BASE + 16'd2;

    logic [7:0]  irq_d;
    logic        armed;
    logic [7:0]  imask;
    logic [7:0]  ipend;
    logic [1:0]  state;
    logic [2:0]  id;

    logic [7:0]  irq_edge;
    logic [7:0]  pend_clr;
    logic [7:0]  candidate;
    logic [2:0]  win_idx;
    logic        withdraw;
    logic [1:0]  state_nxt;
    logic [2:0]  id_nxt;
    logic [15:0] vect_calc;
    logic [7:0]  istat;

    // armed stays low for the first cycle after reset so a line already high is not an edge.
    assign irq_edge  = armed ? (irq & ~irq_d) : 8'h00;
    assign candidate = ipend & imask;
    assign withdraw  = !ipend[id] || !imask[id] || !sreg_i;
    assign istat     = {state, 3'b000, id};
    assign vect_calc = VECT_BASE + VECT_STEP * {13'd0, id_nxt};

    // NOTE: every signal gets a default before the conditional updates, so no latches are inferred.
    always_comb begin
        pend_clr = 8'h00;
        if (w && address == ADDR_IPEND)
            pend_clr = wb;
        if (state == REQ && intr_ack)
            pend_clr[id] = 1'b1;
    end

    // Scan downwards so the lowest set index is the last to be assigned.
    always_comb begin
        win_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (candidate[i])
                win_idx = 3'(i);
        end
    end

    always_comb begin
        state_nxt = state;
        id_nxt    = id;
        case (state)
            IDLE: begin
                if (sreg_i && |candidate) begin
                    state_nxt = REQ;
                    id_nxt    = win_idx;
                end
            end
            REQ: begin
                if (intr_ack)
                    state_nxt = SERVICE;
                else if (withdraw)
                    state_nxt = IDLE;
            end
            SERVICE: begin
                if (reti)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_d <= 8'h00;
            armed <= 1'b0;
            imask <= 8'h00;
            ipend <= 8'h00;
        end else begin
            irq_d <= irq;
            armed <= 1'b1;
            if (w && address == ADDR_IMASK)
                imask <= wb;
            // A new edge is OR-ed in after the clear, so the set wins a same-cycle collision.
            ipend <= (ipend & ~pend_clr) | irq_edge;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            id        <= 3'd0;
            intr_req  <= 1'b0;
            intr_vect <= 16'h0000;
        end else begin
            state     <= state_nxt;
            id        <= id_nxt;
            intr_req  <= (state_nxt == REQ);
            intr_vect <= (state_nxt == REQ) ? vect_calc : 16'h0000;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout <= 8'h00;
        end else begin
            case (address)
                ADDR_IMASK: dout <= imask;
                ADDR_IPEND: dout <= ipend;
                ADDR_ISTAT: dout <= istat;
                default:    dout <= 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: a per-cycle vector table for the basic request/register path,
// then hand-written sequences for priority, withdrawal, masking, set-vs-clear and reset corners.
module tb_intr_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  irq;
    logic [15:0] address;
    logic [7:0]  wb;
    logic        w;
    logic [7:0]  dout;
    logic        sreg_i;
    logic        intr_req;
    logic [15:0] intr_vect;
    logic        intr_ack;
    logic        reti;

    int total = 0;
    int bad   = 0;

    intr_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .irq       (irq),
        .address   (address),
        .wb        (wb),
        .w         (w),
        .dout      (dout),
        .sreg_i    (sreg_i),
        .intr_req  (intr_req),
        .intr_vect (intr_vect),
        .intr_ack  (intr_ack),
        .reti      (reti)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        wr;
        logic [7:0]  irqv;
        logic        ack;
        logic        rt;
        logic        exp_req;
        logic [15:0] exp_vect;
        logic [7:0]  exp_dout;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        address = a;
        wb      = d;
        w       = 1'b1;
        tick();
        w       = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        address = a;
        tick();
        d = dout;
    endtask

    task automatic pulse_irq(input logic [7:0] v);
        irq = v;
        tick();
        irq = 8'h00;
    endtask

    task automatic do_ack();
        intr_ack = 1'b1;
        tick();
        intr_ack = 1'b0;
    endtask

    task automatic do_reti();
        reti = 1'b1;
        tick();
        reti = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;

        // addr, wdata, wr, irq, ack, reti | req, vect, dout (dout shows pre-edge state)
        tbl[0]  = '{16'h0040, 8'h04, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00};
        tbl[1]  = '{16'h0040, 8'h00, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h04};
        tbl[2]  = '{16'h0041, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0006, 8'h04};
        tbl[3]  = '{16'h0041, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0006, 8'h04};
        tbl[4]  = '{16'h0042, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h42};
        tbl[5]  = '{16'h0042, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h82};
        tbl[6]  = '{16'h0041, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00};
        tbl[7]  = '{16'h0042, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h82};
        tbl[8]  = '{16'h0042, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h82};
        tbl[9]  = '{16'h0042, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h02};
        tbl[10] = '{16'h0042, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h02};
        tbl[11] = '{16'h0040, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h04};
        tbl[12] = '{16'h0000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00};
        tbl[13] = '{16'h0042, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h02};

        reset    = 1'b1;
        irq      = 8'h00;
        address  = 16'h0000;
        wb       = 8'h00;
        w        = 1'b0;
        sreg_i   = 1'b1;
        intr_ack = 1'b0;
        reti     = 1'b0;
        #2;
        check("reset intr_req", intr_req, 1'b0);
        check("reset intr_vect", intr_vect, 16'h0000);
        check("reset dout", dout, 8'h00);
        #10 reset = 1'b0;
        tick();
        tick();

        // Basic request, register reads, ignored ack/reti/ISTAT write
        for (int i = 0; i < 14; i++) begin
            address  = tbl[i].addr;
            wb       = tbl[i].wdata;
            w        = tbl[i].wr;
            irq      = tbl[i].irqv;
            intr_ack = tbl[i].ack;
            reti     = tbl[i].rt;
            tick();
            check($sformatf("vec%0d intr_req", i), intr_req, tbl[i].exp_req);
            check($sformatf("vec%0d intr_vect", i), intr_vect, tbl[i].exp_vect);
            check($sformatf("vec%0d dout", i), dout, tbl[i].exp_dout);
        end
        w = 1'b0; irq = 8'h00; intr_ack = 1'b0; reti = 1'b0;

        // Priority: sources 5 and 1 together
        wr(16'h0040, 8'hFF);
        pulse_irq(8'h22);
        tick();
        check("prio first req", intr_req, 1'b1);
        check("prio first vect", intr_vect, 16'h0004);
        do_ack();
        check("prio ack drops req", intr_req, 1'b0);
        tick();
        check("no nesting in service", intr_req, 1'b0);
        rd(16'h0042, d);
        check("prio istat service", d, 8'h81);
        do_reti();
        check("prio after reti", intr_req, 1'b0);
        tick();
        check("prio second req", intr_req, 1'b1);
        check("prio second vect", intr_vect, 16'h000C);
        do_ack();
        do_reti();

        // Withdrawal by clearing IPEND[3]
        pulse_irq(8'h08);
        tick();
        check("wd req", intr_req, 1'b1);
        check("wd vect", intr_vect, 16'h0008);
        wr(16'h0041, 8'h08);
        address = 16'h0042;
        tick();
        check("wd req dropped", intr_req, 1'b0);
        check("wd vect cleared", intr_vect, 16'h0000);
        check("wd istat pre", dout, 8'h43);
        tick();
        check("wd istat idle", dout, 8'h03);
        do_ack();
        check("wd late ack req", intr_req, 1'b0);
        rd(16'h0042, d);
        check("wd late ack istat", d, 8'h03);
        rd(16'h0041, d);
        check("wd ipend", d, 8'h00);

        // id frozen in REQ, then ack beats sreg_i withdrawal
        pulse_irq(8'h08);
        tick();
        check("freeze vect before", intr_vect, 16'h0008);
        pulse_irq(8'h01);
        tick();
        check("freeze req", intr_req, 1'b1);
        check("freeze vect after", intr_vect, 16'h0008);
        sreg_i   = 1'b0;
        intr_ack = 1'b1;
        tick();
        intr_ack = 1'b0;
        sreg_i   = 1'b1;
        check("ack wins req", intr_req, 1'b0);
        rd(16'h0042, d);
        check("ack wins istat", d, 8'h83);
        do_reti();
        tick();
        check("pending src0 req", intr_req, 1'b1);
        check("pending src0 vect", intr_vect, 16'h0002);
        do_ack();
        do_reti();
        rd(16'h0041, d);
        check("ipend empty", d, 8'h00);

        // Masking and global enable
        wr(16'h0040, 8'h00);
        pulse_irq(8'h01);
        tick();
        check("masked no req", intr_req, 1'b0);
        rd(16'h0041, d);
        check("masked ipend", d, 8'h01);
        sreg_i = 1'b0;
        wr(16'h0040, 8'h01);
        tick();
        tick();
        check("sreg off no req", intr_req, 1'b0);
        sreg_i = 1'b1;
        tick();
        check("sreg on req", intr_req, 1'b1);
        check("sreg on vect", intr_vect, 16'h0002);
        do_ack();
        do_reti();

        // Edge set beats write-one-to-clear
        wr(16'h0040, 8'h00);
        address = 16'h0041;
        wb      = 8'h01;
        w       = 1'b1;
        irq     = 8'h01;
        tick();
        w   = 1'b0;
        irq = 8'h00;
        rd(16'h0041, d);
        check("set beats clear", d, 8'h01);
        wr(16'h0041, 8'h01);
        rd(16'h0041, d);
        check("w1c clears", d, 8'h00);

        // Asynchronous reset in SERVICE with irq[4] held high
        wr(16'h0040, 8'h10);
        irq = 8'h10;
        tick();
        tick();
        check("src4 req", intr_req, 1'b1);
        check("src4 vect", intr_vect, 16'h000A);
        do_ack();
        address = 16'h0040;
        tick();
        check("service dout imask", dout, 8'h10);
        #3 reset = 1'b1;
        #1;
        check("async rst req", intr_req, 1'b0);
        check("async rst vect", intr_vect, 16'h0000);
        check("async rst dout", dout, 8'h00);
        #2 reset = 1'b0;
        rd(16'h0042, d);
        check("post rst istat", d, 8'h00);
        wr(16'h0040, 8'h10);
        tick();
        tick();
        tick();
        check("held line no req", intr_req, 1'b0);
        rd(16'h0041, d);
        check("held line no pend", d, 8'h00);
        irq = 8'h00;
        tick();
        irq = 8'h10;
        tick();
        tick();
        check("new edge req", intr_req, 1'b1);
        check("new edge vect", intr_vect, 16'h000A);
        irq = 8'h00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
